// File: rtl/sd_emmc_pkg.sv
// Shared types and constants for the SD/eMMC CMD-line receiver and transmitter.
package sd_emmc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    HEAD,
    BODY,
    CRC,
    END,
    DONE
  } state_t;

  localparam int SHORT_BODY_BITS = 38;
  localparam int LONG_RSV_BITS   = 6;
  localparam int LONG_DATA_BITS  = 120;
  localparam int CRC7_BITS       = 7;

  localparam logic [6:0] CRC7_POLY = 7'h09;

  // One serial CRC7 step, MSB-first, feedback taps from x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = crc[6] ^ din;
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_emmc_crc7.sv
// Serial CRC7 generator/checker; clr and en together restart the CRC from the current bit.
module sd_emmc_crc7
  import sd_emmc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] base;

  assign base = clr ? 7'h00 : crc;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= 7'h00;
    end else if (en) begin
      crc <= crc7_step(base, din);
    end else if (clr) begin
      crc <= 7'h00;
    end
  end

endmodule

// File: rtl/sd_emmc_cmd_rx.sv
// SD/eMMC CMD-line response receiver: start-bit hunt with timeout, 48/136-bit
// deserialisation and CRC7 / transmission-bit / end-bit checking.
module sd_emmc_cmd_rx
  import sd_emmc_pkg::*;
#(
  parameter int TO_W      = 8,
  parameter bit CRC_EN_R3 = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sample_en,
  input  logic            cmd_in,
  input  logic            start,
  input  logic            abort,
  input  logic            resp_long,
  input  logic            resp_nocrc,
  input  logic [TO_W-1:0] timeout_cycles,
  output logic            busy,
  output logic            done,
  output logic            timeout,
  output logic            crc_err,
  output logic            tx_err,
  output logic            end_err,
  output logic [5:0]      resp_index,
  output logic [127:0]    resp_data
);

  localparam logic [6:0] SHORT_LAST = 7'(SHORT_BODY_BITS - 1);
  localparam logic [6:0] LONG_FIRST = 7'(LONG_RSV_BITS);
  localparam logic [6:0] LONG_LAST  = 7'(LONG_RSV_BITS + LONG_DATA_BITS - 1);
  localparam logic [6:0] CRC_LAST   = 7'(CRC7_BITS - 1);

  state_t          state, state_nxt;
  logic            long_r, nocrc_r, tx_err_r;
  logic [TO_W-1:0] tmo_r, to_cnt;
  logic [6:0]      bit_cnt;
  logic [6:0]      crc_rx, crc_calc;
  logic [126:0]    shreg;
  logic            crc_clr, crc_en;
  logic            rsv_bit, first_data, body_last, crc_last, to_hit, crc_chk;

  assign rsv_bit    = long_r && (bit_cnt < LONG_FIRST);
  assign first_data = long_r && (bit_cnt == LONG_FIRST);
  assign body_last  = long_r ? (bit_cnt == LONG_LAST) : (bit_cnt == SHORT_LAST);
  assign crc_last   = (bit_cnt == CRC_LAST);
  assign to_hit     = (tmo_r != '0) && ((to_cnt + TO_W'(1)) == tmo_r);
  assign crc_chk    = !nocrc_r || CRC_EN_R3;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  sd_emmc_crc7 u_crc7 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (crc_clr),
    .en    (crc_en),
    .din   (cmd_in),
    .crc   (crc_calc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt = state;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          crc_clr = start;
          if (start) state_nxt = WAIT_START;
        end
        WAIT_START: begin
          crc_en = sample_en && !cmd_in;
          if (sample_en) begin
            if (!cmd_in)    state_nxt = HEAD;
            else if (to_hit) state_nxt = DONE;
          end
        end
        HEAD: begin
          crc_en = sample_en;
          if (sample_en) state_nxt = BODY;
        end
        BODY: begin
          // Long-frame reserved bits stay out of the CRC; it restarts on the first data bit.
          crc_en  = sample_en && !rsv_bit;
          crc_clr = sample_en && first_data;
          if (sample_en && body_last) state_nxt = CRC;
        end
        CRC:     if (sample_en && crc_last) state_nxt = END;
        END:     if (sample_en) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_r     <= 1'b0;
      nocrc_r    <= 1'b0;
      tx_err_r   <= 1'b0;
      tmo_r      <= '0;
      to_cnt     <= '0;
      bit_cnt    <= '0;
      crc_rx     <= '0;
      shreg      <= '0;
      timeout    <= 1'b0;
      crc_err    <= 1'b0;
      tx_err     <= 1'b0;
      end_err    <= 1'b0;
      resp_index <= '0;
      resp_data  <= '0;
    end else if (!abort) begin
      if (state == IDLE && start) begin
        long_r  <= resp_long;
        nocrc_r <= resp_nocrc;
        tmo_r   <= timeout_cycles;
        to_cnt  <= '0;
      end
      if (sample_en) begin
        case (state)
          WAIT_START: begin
            if (cmd_in) begin
              to_cnt <= to_cnt + TO_W'(1);
              if (to_hit) begin
                timeout <= 1'b1;
                crc_err <= 1'b0;
                tx_err  <= 1'b0;
                end_err <= 1'b0;
              end
            end
          end
          HEAD: begin
            tx_err_r <= cmd_in;
            bit_cnt  <= '0;
          end
          BODY: begin
            if (!rsv_bit) shreg <= {shreg[125:0], cmd_in};
            bit_cnt <= body_last ? 7'd0 : bit_cnt + 7'd1;
          end
          CRC: begin
            crc_rx <= {crc_rx[5:0], cmd_in};
            if (long_r) shreg <= {shreg[125:0], cmd_in};
            bit_cnt <= bit_cnt + 7'd1;
          end
          END: begin
            timeout <= 1'b0;
            tx_err  <= tx_err_r;
            end_err <= !cmd_in;
            crc_err <= (crc_rx != crc_calc) && crc_chk;
            if (long_r) begin
              resp_index <= 6'h3F;
              resp_data  <= {shreg, 1'b0};
            end else begin
              resp_index <= shreg[37:32];
              resp_data  <= {96'h0, shreg[31:0]};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
